// File: rtl/stream_demux_pkg.sv
// Shared types for the packet-aware stream demultiplexer.
// Holds the packet-tracking FSM encoding.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DROP = 2'd2
    } state_e;

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry valid/ready register slice feeding a single demux output.
// A load and a drain in the same cycle keep the slot full with no bubble.
module demux_slot #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_payload,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_payload,
    output logic         o_free
);

    logic         r_valid;
    logic [W-1:0] r_payload;

    assign o_valid   = r_valid;
    assign o_payload = r_payload;
    assign o_free    = !r_valid || i_ready;

    // Load wins over drain; payload holds steady while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (i_load) begin
            r_valid   <= 1'b1;
            r_payload <= i_payload;
        end else if (i_ready) begin
            r_valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Packet-aware 1-to-NUM_OUT stream demultiplexer.
// Destination is taken on the first beat and locked until the last beat.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int NUM_OUT = 4,
    parameter  int DATA_W  = 8,
    localparam int SEL_W   = $clog2(NUM_OUT)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [DATA_W-1:0]         in_data_i,
    input  logic                      in_last_i,
    input  logic [SEL_W-1:0]          sel_i,
    output logic [NUM_OUT-1:0]        out_valid_o,
    input  logic [NUM_OUT-1:0]        out_ready_i,
    output logic [NUM_OUT*DATA_W-1:0] out_data_o,
    output logic [NUM_OUT-1:0]        out_last_o,
    output logic                      err_sel_o
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic               r_err;
    logic               w_err_nxt;

    logic               w_sel_ok;
    logic [SEL_W-1:0]   w_tgt;
    logic               w_tgt_ok;
    logic [NUM_OUT-1:0] w_tgt_oh;
    logic [NUM_OUT-1:0] w_free;
    logic               w_tgt_free;
    logic               w_accept;
    logic [DATA_W:0]    w_slot_pl [NUM_OUT];

    assign w_sel_ok  = (32'(sel_i) < NUM_OUT);
    assign w_accept  = in_valid_i && in_ready_o;
    assign err_sel_o = r_err;

    // Target decode: live sel when idle, locked sel mid-packet, none when dropping.
    always_comb begin
        w_tgt    = (r_state == ST_BUSY) ? r_sel : sel_i;
        w_tgt_ok = 1'b0;
        unique case (r_state)
            ST_IDLE: w_tgt_ok = w_sel_ok;
            ST_BUSY: w_tgt_ok = 1'b1;
            ST_DROP: w_tgt_ok = 1'b0;
            default: w_tgt_ok = 1'b0;
        endcase
        for (int k = 0; k < NUM_OUT; k++) begin
            w_tgt_oh[k] = w_tgt_ok && (32'(w_tgt) == k);
        end
        w_tgt_free = |(w_free & w_tgt_oh);
    end

    // Ready looks only at the target slot; discarded beats always go through.
    always_comb begin
        in_ready_o = 1'b0;
        if (!reset) begin
            in_ready_o = w_tgt_ok ? w_tgt_free : 1'b1;
        end
    end

    // Packet FSM next-state, sel lock and bad-select detection.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_err_nxt   = 1'b0;
        if (w_accept) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_sel_ok) begin
                        w_sel_nxt = sel_i;
                        if (!in_last_i) w_state_nxt = ST_BUSY;
                    end else begin
                        w_err_nxt = 1'b1;
                        if (!in_last_i) w_state_nxt = ST_DROP;
                    end
                end
                ST_BUSY: if (in_last_i) w_state_nxt = ST_IDLE;
                ST_DROP: if (in_last_i) w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM, locked select and error pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_err   <= w_err_nxt;
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        demux_slot #(
            .W(DATA_W + 1)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .i_load    (w_accept && w_tgt_oh[k]),
            .i_payload ({in_last_i, in_data_i}),
            .i_ready   (out_ready_i[k]),
            .o_valid   (out_valid_o[k]),
            .o_payload (w_slot_pl[k]),
            .o_free    (w_free[k])
        );
        assign out_data_o[k*DATA_W +: DATA_W] = w_slot_pl[k][DATA_W-1:0];
        assign out_last_o[k]                  = w_slot_pl[k][DATA_W];
    end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux (3 outputs, 8-bit data).
// Directed packets followed by randomized traffic against a packet-level model.
module tb_stream_demux;

    localparam int N = 3;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           vld;
    logic           in_ready;
    logic [W-1:0]   dat;
    logic           lst;
    logic [1:0]     sel;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   ordy;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_last;
    logic           err;

    int n_tests = 0;
    int n_fail  = 0;

    // packet-level model: one held beat per channel plus packet routing state
    bit         mv [N];
    logic [7:0] md [N];
    logic       ml [N];
    bit         m_inpkt;
    int         m_ch;
    bit         m_err;
    logic       tb_rdy;

    always #5 clk = ~clk;

    stream_demux #(
        .NUM_OUT(N),
        .DATA_W (W)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .in_valid_i (vld),
        .in_ready_o (in_ready),
        .in_data_i  (dat),
        .in_last_i  (lst),
        .sel_i      (sel),
        .out_valid_o(out_valid),
        .out_ready_i(ordy),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .err_sel_o  (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check ready, advance model at the edge, check outputs.
    task automatic cycle();
        logic exp_rdy;
        logic acc;
        int   ch;
        #1;
        if (rst) exp_rdy = 1'b0;
        else if (!m_inpkt) exp_rdy = (sel >= 2'd3) ? 1'b1 : (!mv[sel] || ordy[sel]);
        else if (m_ch < 0) exp_rdy = 1'b1;
        else exp_rdy = !mv[m_ch] || ordy[m_ch];
        tb_rdy = in_ready;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        acc = vld && exp_rdy;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < N; k++) mv[k] = 0;
            m_inpkt = 0;
            m_err   = 0;
            m_ch    = -1;
        end else begin
            for (int k = 0; k < N; k++) if (mv[k] && ordy[k]) mv[k] = 0;
            m_err = 0;
            ch    = -1;
            if (acc) begin
                if (!m_inpkt) begin
                    ch      = (int'(sel) < N) ? int'(sel) : -1;
                    m_err   = (ch < 0);
                    m_ch    = ch;
                    m_inpkt = !lst;
                end else begin
                    ch = m_ch;
                    if (lst) m_inpkt = 0;
                end
                if (ch >= 0) begin
                    mv[ch] = 1;
                    md[ch] = dat;
                    ml[ch] = lst;
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("valid%0d", k), {31'd0, out_valid[k]}, {31'd0, mv[k]});
            if (mv[k]) begin
                chk($sformatf("data%0d", k), {24'd0, out_data[k*W +: W]}, {24'd0, md[k]});
                chk($sformatf("last%0d", k), {31'd0, out_last[k]}, {31'd0, ml[k]});
            end
        end
        chk("err_sel", {31'd0, err}, {31'd0, m_err});
    endtask

    task automatic beat(input logic [1:0] s, input logic [7:0] d, input logic l);
        vld = 1'b1;
        sel = s;
        dat = d;
        lst = l;
        cycle();
        vld = 1'b0;
    endtask

    initial begin
        m_inpkt = 0;
        m_ch    = -1;
        m_err   = 0;
        for (int k = 0; k < N; k++) begin
            mv[k] = 0;
            md[k] = '0;
            ml[k] = 0;
        end
        rst  = 1'b1;
        vld  = 1'b1;
        dat  = 8'hFF;
        lst  = 1'b0;
        sel  = 2'd1;
        ordy = 3'b111;

        // 1: reset with valid held high
        cycle();
        cycle();
        chk("rst_valid", {29'd0, out_valid}, 32'd0);
        chk("rst_data", {8'd0, out_data}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ready", {31'd0, tb_rdy}, 32'd0);
        rst = 1'b0;
        vld = 1'b0;

        // 2: back-to-back single-beat packets
        beat(2'd0, 8'hA5, 1'b1);
        chk("t2_v0", {29'd0, out_valid}, 32'b001);
        chk("t2_d0", {24'd0, out_data[7:0]}, 32'hA5);
        chk("t2_r0", {31'd0, tb_rdy}, 32'd1);
        beat(2'd1, 8'h5A, 1'b1);
        chk("t2_v1", {29'd0, out_valid}, 32'b010);
        chk("t2_d1", {24'd0, out_data[15:8]}, 32'h5A);
        beat(2'd2, 8'h3C, 1'b1);
        chk("t2_v2", {29'd0, out_valid}, 32'b100);
        chk("t2_d2", {24'd0, out_data[23:16]}, 32'h3C);
        chk("t2_r2", {31'd0, tb_rdy}, 32'd1);

        // 3: sel changes mid-packet are ignored
        beat(2'd2, 8'h10, 1'b0);
        beat(2'd0, 8'h11, 1'b0);
        beat(2'd0, 8'h12, 1'b0);
        beat(2'd0, 8'h13, 1'b1);
        chk("t3_v", {29'd0, out_valid}, 32'b100);
        chk("t3_d", {24'd0, out_data[23:16]}, 32'h13);
        chk("t3_l", {31'd0, out_last[2]}, 32'd1);
        cycle();

        // 4: stalled channel then release with no bubble
        ordy = 3'b101;
        beat(2'd1, 8'h21, 1'b0);
        beat(2'd0, 8'h22, 1'b1);
        chk("t4_stall_rdy", {31'd0, tb_rdy}, 32'd0);
        chk("t4_hold", {24'd0, out_data[15:8]}, 32'h21);
        ordy = 3'b111;
        beat(2'd0, 8'h22, 1'b1);
        chk("t4_rel_rdy", {31'd0, tb_rdy}, 32'd1);
        chk("t4_b2", {24'd0, out_data[15:8]}, 32'h22);
        chk("t4_b2l", {31'd0, out_last[1]}, 32'd1);
        cycle();

        // 5: invalid select drops the packet with one error pulse
        beat(2'd3, 8'h40, 1'b0);
        chk("t5_err1", {31'd0, err}, 32'd1);
        beat(2'd1, 8'h41, 1'b0);
        chk("t5_err2", {31'd0, err}, 32'd0);
        beat(2'd1, 8'h42, 1'b1);
        chk("t5_none", {29'd0, out_valid}, 32'd0);
        beat(2'd0, 8'h77, 1'b1);
        chk("t5_ok", {24'd0, out_data[7:0]}, 32'h77);
        cycle();

        // 6: reset mid-packet
        beat(2'd1, 8'h31, 1'b0);
        beat(2'd1, 8'h32, 1'b0);
        rst = 1'b1;
        cycle();
        chk("t6_clr", {29'd0, out_valid}, 32'd0);
        rst = 1'b0;
        beat(2'd0, 8'hEE, 1'b1);
        chk("t6_v", {29'd0, out_valid}, 32'b001);
        chk("t6_d", {24'd0, out_data[7:0]}, 32'hEE);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            vld  = ($urandom_range(0, 3) != 0);
            sel  = 2'($urandom_range(0, 3));
            dat  = 8'($urandom);
            lst  = ($urandom_range(0, 2) == 0);
            ordy = 3'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
